// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// The optional lock watchdog in rst_seq_ctrl is enabled by defining RST_SEQ_WDOG_EN.
package rst_seq_pkg;

    localparam int FAULT_CNT_W = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        DEBOUNCE,
        RELEASE,
        RUN,
        FLUSH
    } seq_state_e;

    // Width that holds 0..value-1, never narrower than one bit.
    function automatic int clog2w(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module cdc_sync_bit #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Lock-driven reset sequencer: releases N_DOM synchronous resets in ascending order.
// Define RST_SEQ_WDOG_EN to add the lock watchdog (wdog_to, pll_rst_req).
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_DOM       = 3,
    parameter int STAGE_DLY   = 16,
    parameter int LOCK_DEB    = 8,
    parameter int SYNC_STAGES = 3
`ifdef RST_SEQ_WDOG_EN
    ,
    parameter int WDOG_CYC    = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   lock_async,
    input  logic                   sw_rst_req,
    output logic [N_DOM-1:0]       dom_srst,
    output logic                   all_rdy,
    output logic                   lock_lost,
    output logic [FAULT_CNT_W-1:0] fault_cnt
`ifdef RST_SEQ_WDOG_EN
    ,
    output logic                   wdog_to,
    output logic                   pll_rst_req
`endif
);

    localparam int DEB_W = clog2w(LOCK_DEB);
    localparam int DLY_W = clog2w(STAGE_DLY);
    localparam int STG_W = clog2w(N_DOM);

    localparam logic [DEB_W-1:0]       DEB_LAST  = DEB_W'(LOCK_DEB - 1);
    localparam logic [DLY_W-1:0]       DLY_LAST  = DLY_W'(STAGE_DLY - 1);
    localparam logic [STG_W-1:0]       STG_LAST  = STG_W'(N_DOM - 1);
    localparam logic [FAULT_CNT_W-1:0] FAULT_MAX = '1;

    logic lock_s;

    seq_state_e             state_reg, state_next;
    logic [DEB_W-1:0]       deb_cnt_reg, deb_cnt_next;
    logic [DLY_W-1:0]       dly_cnt_reg, dly_cnt_next;
    logic [STG_W-1:0]       stage_reg, stage_next;
    logic [N_DOM-1:0]       dom_srst_reg, dom_srst_next;
    logic                   all_rdy_reg, all_rdy_next;
    logic                   lock_lost_reg, lock_lost_next;
    logic [FAULT_CNT_W-1:0] fault_cnt_reg, fault_cnt_next;
    logic                   loss_evt;

    cdc_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (lock_async),
        .q      (lock_s)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg     <= WAIT_LOCK;
            deb_cnt_reg   <= '0;
            dly_cnt_reg   <= '0;
            stage_reg     <= '0;
            dom_srst_reg  <= '1;
            all_rdy_reg   <= 1'b0;
            lock_lost_reg <= 1'b0;
            fault_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            deb_cnt_reg   <= deb_cnt_next;
            dly_cnt_reg   <= dly_cnt_next;
            stage_reg     <= stage_next;
            dom_srst_reg  <= dom_srst_next;
            all_rdy_reg   <= all_rdy_next;
            lock_lost_reg <= lock_lost_next;
            fault_cnt_reg <= fault_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        deb_cnt_next  = deb_cnt_reg;
        dly_cnt_next  = dly_cnt_reg;
        stage_next    = stage_reg;
        dom_srst_next = dom_srst_reg;
        all_rdy_next  = all_rdy_reg;
        loss_evt      = 1'b0;

        case (state_reg)
            WAIT_LOCK: begin
                deb_cnt_next  = '0;
                dom_srst_next = '1;
                if (lock_s) begin
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // A lock drop here only restarts the debounce; it is not a fault.
                if (!lock_s) begin
                    state_next   = WAIT_LOCK;
                    deb_cnt_next = '0;
                end else if (sw_rst_req) begin
                    state_next    = FLUSH;
                    dly_cnt_next  = '0;
                    dom_srst_next = '1;
                    all_rdy_next  = 1'b0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    state_next   = RELEASE;
                    deb_cnt_next = '0;
                    stage_next   = '0;
                    dly_cnt_next = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end
            RELEASE, RUN: begin
                if (!lock_s || sw_rst_req) begin
                    loss_evt      = !lock_s;
                    state_next    = FLUSH;
                    dly_cnt_next  = '0;
                    dom_srst_next = '1;
                    all_rdy_next  = 1'b0;
                end else if (state_reg == RELEASE) begin
                    if (dly_cnt_reg == DLY_LAST) begin
                        dom_srst_next[stage_reg] = 1'b0;
                        dly_cnt_next             = '0;
                        if (stage_reg == STG_LAST) begin
                            state_next   = RUN;
                            all_rdy_next = 1'b1;
                        end else begin
                            stage_next = stage_reg + STG_W'(1);
                        end
                    end else begin
                        dly_cnt_next = dly_cnt_reg + DLY_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (dly_cnt_reg == DLY_LAST) begin
                    state_next   = WAIT_LOCK;
                    dly_cnt_next = '0;
                end else begin
                    dly_cnt_next = dly_cnt_reg + DLY_W'(1);
                end
            end
            default: begin
                state_next    = WAIT_LOCK;
                dom_srst_next = '1;
                all_rdy_next  = 1'b0;
            end
        endcase
    end

    // A counted lock loss wins over a same-cycle software clear.
    always_comb begin
        lock_lost_next = lock_lost_reg;
        fault_cnt_next = fault_cnt_reg;
        if (loss_evt) begin
            lock_lost_next = 1'b1;
            if (fault_cnt_reg != FAULT_MAX) begin
                fault_cnt_next = fault_cnt_reg + FAULT_CNT_W'(1);
            end
        end else if (sw_rst_req) begin
            lock_lost_next = 1'b0;
        end
    end

    assign dom_srst  = dom_srst_reg;
    assign all_rdy   = all_rdy_reg;
    assign lock_lost = lock_lost_reg;
    assign fault_cnt = fault_cnt_reg;

`ifdef RST_SEQ_WDOG_EN
    localparam int                WDOG_W    = clog2w(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0] wdog_cnt_reg;
    logic              wdog_to_reg;
    logic              pll_req_reg;
    logic [1:0]        pll_cnt_reg;
    logic              run_entry;
    logic              waiting;

    assign run_entry = (state_next == RUN) && (state_reg != RUN);
    assign waiting   = (state_reg == WAIT_LOCK) || (state_reg == DEBOUNCE);

    // pll_rst_req stays high for the trigger cycle plus three countdown cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wdog_cnt_reg <= '0;
            wdog_to_reg  <= 1'b0;
            pll_req_reg  <= 1'b0;
            pll_cnt_reg  <= '0;
        end else begin
            if (run_entry) begin
                wdog_cnt_reg <= '0;
                wdog_to_reg  <= 1'b0;
            end else if (waiting) begin
                if (wdog_cnt_reg == WDOG_LAST) begin
                    wdog_cnt_reg <= '0;
                    wdog_to_reg  <= 1'b1;
                end else begin
                    wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
                end
            end

            if (waiting && !run_entry && (wdog_cnt_reg == WDOG_LAST)) begin
                pll_req_reg <= 1'b1;
                pll_cnt_reg <= 2'd3;
            end else if (pll_cnt_reg != 2'd0) begin
                pll_cnt_reg <= pll_cnt_reg - 2'd1;
            end else begin
                pll_req_reg <= 1'b0;
            end
        end
    end

    assign wdog_to     = wdog_to_reg;
    assign pll_rst_req = pll_req_reg;
`else
    // Without the watchdog the sequencer waits in WAIT_LOCK indefinitely.
`endif

endmodule
